i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter QDIV, default 4: clk cycles per SCL quarter-period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: sole clock.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: transaction request, sampled only when ready=1.
REQ-005 SHALL have port addr, input, 7: target slave address, captured with enable.
REQ-006 SHALL have port rw, input, 1: 1 = read, 0 = write; captured with enable.
REQ-007 SHALL have port data_in, input, 8: write byte, captured with enable.
REQ-008 SHALL have port data_out, output, 8: last read byte, held until the next read completes.
REQ-009 SHALL have port ready, output, 1: high only in IDLE.
REQ-010 SHALL have port ack_err, output, 1: NACK seen on the last transaction; cleared on the next accepted enable.
REQ-011 SHALL have port scl, output, 1: I2C clock, push-pull, idles high.
REQ-012 SHALL have port sda_oe, output, 1: 1 = pull SDA low; 0 = release SDA. SDA is never driven high.
REQ-013 SHALL have port sda_in, input, 1: resolved SDA bus level.
REQ-014 SHALL have port state, output, 4: current FSM state, exported for assertion binding.

Function
REQ-015 SHALL implement FSM states IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WDATA=4, WACK=5, RDATA=6, RACK=7, STOP=8; all other encodings SHALL return to IDLE on the next cycle.
REQ-016 SHALL use a quarter-phase counter with QDIV cycles per quarter; one bit = 4 quarters (SCL low, low, high, high).
REQ-017 SHALL change sda_oe only during an SCL-low quarter, except at START and STOP.
REQ-018 On enable with ready=1, SHALL capture addr, rw and data_in, then enter START on the next cycle; ready SHALL fall in that same cycle.
REQ-019 START: with scl=1, SHALL assert sda_oe; SHALL then drive scl low after 2 quarters.
REQ-020 ADDR: SHALL shift {addr, rw} MSB first over 8 bits.
REQ-021 ADDR_ACK/WACK: SHALL release SDA and sample sda_in at the second high quarter. A value of 1 SHALL set ack_err and go to STOP.
REQ-022 After ADDR_ACK with ACK: rw=0 SHALL go to WDATA; rw=1 SHALL go to RDATA.
REQ-023 WDATA: SHALL shift the captured byte MSB first, then go to WACK, then STOP.
REQ-024 RDATA: SHALL release SDA and sample sda_in at mid-high of each bit, MSB first. RACK SHALL send NACK (release SDA), then go to STOP; data_out SHALL update on entry to RACK.
REQ-025 STOP: SHALL assert sda_oe during SCL low, raise scl, and release SDA after 1 high quarter; the FSM SHALL return to IDLE 1 quarter later.
REQ-026 A transaction SHALL be exactly one address byte plus one data byte; there are no repeated-START or multi-byte transfers.
REQ-027 enable while ready=0 SHALL be ignored; enable held high in IDLE SHALL start back-to-back transactions.
REQ-028 Bit counter (3 bit) SHALL count 7 down to 0; the ACK phase SHALL follow when it reaches 0.

Reset
REQ-029 rst SHALL force, on the next clk edge and from any state: state=IDLE, scl=1, sda_oe=0, ready=1, ack_err=0, data_out=0, and zero counters.
REQ-030 rst mid-transaction SHALL abandon the transaction with no STOP generated; the bus SHALL be released within 1 cycle.

Structure
REQ-031 SHALL take the state enum and the state encodings from the shared package i2c_pkg, along with I2C_ADDR_W=7 and I2C_DATA_W=8.
REQ-032 SHALL place the quarter-phase divider in the sub-module i2c_clk_gen (outputs: quarter tick, phase[1:0]).
REQ-033 SHALL keep the state width at 4 bits so that the existing assertion binds apply without modification.

Verification
REQ-034 Write: addr=0x50, rw=0, data_in=0xA5, slave ACKs both bytes -> SDA bits 1010000_0 then 10100101, ack_err=0, ready returns to 1.
REQ-035 Read: addr=0x51, rw=1, slave returns 0x3C -> data_out=0x3C, master NACKs, STOP seen, ack_err=0.
REQ-036 Address NACK: sda_in held high at ADDR_ACK -> ack_err=1, STOP follows, WDATA never entered.
REQ-037 Reset asserted in WDATA bit 4 -> next edge: state=0, scl=1, sda_oe=0, ready=1.
REQ-038 QDIV=2: SCL period = 8 clk; no SDA edge occurs while scl=1 outside START/STOP.
REQ-039 enable pulsed while busy -> ignored; enable held high -> second transaction starts 1 cycle after IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding and field widths
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
    ADDR     = 4'd2,
    ADDR_ACK = 4'd3,
    WDATA    = 4'd4,
    WACK     = 4'd5,
    RDATA    = 4'd6,
    RACK     = 4'd7,
    STOP     = 4'd8
  } state_t;
endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: quarter-period tick and 2-bit SCL phase counter
module i2c_clk_gen #(parameter int QDIV = 4) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] phase
);
  logic [7:0] cnt;
  assign tick = cnt == 8'(QDIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= '0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single address+data byte I2C master with quarter-phase SCL timing
module i2c_master import i2c_pkg::*; #(parameter int QDIV = 4) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [I2C_ADDR_W-1:0] addr,
  input  logic                  rw,
  input  logic [I2C_DATA_W-1:0] data_in,
  output logic [I2C_DATA_W-1:0] data_out,
  output logic                  ready,
  output logic                  ack_err,
  output logic                  scl,
  output logic                  sda_oe,
  input  logic                  sda_in,
  output logic [3:0]            state
);
  state_t st;
  logic tick, clr, last, rd;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [I2C_ADDR_W:0] sh;
  logic [I2C_DATA_W-1:0] wd, rsh;
  assign state = st;
  assign last = bit_cnt == 3'd0;
  // phase restarts at 0 when leaving START so every bit begins on an SCL-low quarter
  assign clr = st == IDLE || (st == START && tick && phase == 2'd1);
  i2c_clk_gen #(.QDIV(QDIV)) u_clk_gen (.clk, .rst, .clr, .tick, .phase);
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      ready    <= 1'b1;
      ack_err  <= 1'b0;
      data_out <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      wd       <= '0;
      rsh      <= '0;
      rd       <= 1'b0;
    end else begin
      case (st)
        IDLE: if (enable) begin
          sh      <= {addr, rw};
          wd      <= data_in;
          rd      <= rw;
          bit_cnt <= 3'd7;
          ack_err <= 1'b0;
          ready   <= 1'b0;
          sda_oe  <= 1'b1;
          st      <= START;
        end
        START: if (tick && phase == 2'd1) begin
          scl <= 1'b0;
          st  <= ADDR;
        end
        ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK: if (tick) begin
          if (phase == 2'd0) sda_oe <= st == ADDR ? ~sh[bit_cnt] : st == WDATA ? ~wd[bit_cnt] : 1'b0;
          if (phase == 2'd1) scl <= 1'b1;
          if (phase == 2'd2 && st == RDATA) rsh <= {rsh[6:0], sda_in};
          if (phase == 2'd3) begin
            scl <= 1'b0;
            if (st == ADDR || st == WDATA || st == RDATA) bit_cnt <= bit_cnt - 3'd1;
            if (st == RDATA && last) data_out <= rsh;
            if ((st == ADDR_ACK || st == WACK) && sda_in) ack_err <= 1'b1;
            st <= st == ADDR ? (last ? ADDR_ACK : ADDR) :
                  st == WDATA ? (last ? WACK : WDATA) :
                  st == RDATA ? (last ? RACK : RDATA) :
                  (st == ADDR_ACK && !sda_in) ? (rd ? RDATA : WDATA) : STOP;
          end
        end
        STOP: if (tick) begin
          if (phase == 2'd0) sda_oe <= 1'b1;
          if (phase == 2'd1) scl <= 1'b1;
          if (phase == 2'd2) sda_oe <= 1'b0;
          if (phase == 2'd3) begin
            st    <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          st     <= IDLE;
          scl    <= 1'b1;
          sda_oe <= 1'b0;
          ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: random I2C transactions checked by a bus-level monitor and slave model
module tb_i2c_master;
  localparam int Q = 2;
  logic clk = 0, rst = 1, enable = 0, rw = 0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0, data_out;
  logic ready, ack_err, scl, sda_oe, sda_in;
  logic [3:0] state;
  logic pull = 0;
  int total = 0, bad = 0;
  bit cfg_aa = 1, cfg_ad = 1, cfg_rw = 0;
  logic [7:0] cfg_rb = '0, exp_dout = '0;
  bit bits[$];
  int starts = 0, stops = 0, pmin = 0, pmax = 0, nf = 0, cyc = 0, last_rise = 0;
  bit have_rise = 0;
  logic pscl = 1, psda = 1;

  assign sda_in = ~sda_oe & ~pull;

  i2c_master #(.QDIV(Q)) dut (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out), .ready(ready), .ack_err(ack_err), .scl(scl), .sda_oe(sda_oe),
    .sda_in(sda_in), .state(state)
  );

  always #5 clk = ~clk;

  // slave behaviour for the SCL-low period that precedes bit k of the frame
  function automatic logic slave_pull(input int k);
    if (k == 8) return cfg_aa;
    if (k >= 9 && k <= 16) return cfg_aa && cfg_rw && !cfg_rb[16-k];
    if (k == 17) return cfg_aa && !cfg_rw && cfg_ad;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic cur;
    cur = sda_in;
    cyc++;
    if (rst) begin
      pull = 0;
      nf = 0;
    end else begin
      if (pscl && scl && psda && !cur) begin
        starts++;
        bits.delete();
        nf = 0;
        have_rise = 0;
        pmin = 999;
        pmax = 0;
      end
      if (pscl && scl && !psda && cur) begin
        stops++;
        if (bits.size() > 0) void'(bits.pop_back());
      end
      if (!pscl && scl) begin
        bits.push_back(cur);
        if (have_rise) begin
          if (cyc - last_rise < pmin) pmin = cyc - last_rise;
          if (cyc - last_rise > pmax) pmax = cyc - last_rise;
        end
        last_rise = cyc;
        have_rise = 1;
      end
      if (pscl && !scl) begin
        nf++;
        pull = slave_pull(nf - 1);
      end
    end
    pscl = scl;
    psda = cur;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (ready !== lvl && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 32'(ready), 32'(lvl));
  endtask

  task automatic check_bits(input bit exp_q[$]);
    logic [31:0] gv = '0, ev = '0;
    chk("nbits", bits.size(), exp_q.size());
    foreach (exp_q[i]) begin
      ev = {ev[30:0], exp_q[i]};
      gv = {gv[30:0], i < bits.size() ? bits[i] : 1'b0};
    end
    chk("bits", gv, ev);
  endtask

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input bit aa, input bit ad, input logic [7:0] rb, input bit poke);
    int s0, p0;
    bit exp_q[$];
    logic [7:0] byt;
    cfg_aa = aa; cfg_ad = ad; cfg_rw = r; cfg_rb = rb;
    addr = a; rw = r; data_in = d; enable = 1;
    s0 = starts; p0 = stops;
    @(posedge clk);
    #1;
    enable = 0;
    chk("ready_fall", 32'(ready), 0);
    chk("start_state", 32'(state), 1);
    if (poke) begin
      repeat (60) @(posedge clk);
      #1;
      addr = ~a; rw = ~r; enable = 1;
      @(posedge clk);
      #1;
      enable = 0;
    end
    wait_ready(1);
    byt = {a, r};
    for (int i = 7; i >= 0; i--) exp_q.push_back(byt[i]);
    exp_q.push_back(!aa);
    if (aa) begin
      byt = r ? rb : d;
      for (int i = 7; i >= 0; i--) exp_q.push_back(byt[i]);
      exp_q.push_back(r ? 1'b1 : !ad);
    end
    if (r && aa) exp_dout = rb;
    check_bits(exp_q);
    chk("ack_err", 32'(ack_err), 32'(!aa || (!r && !ad)));
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("starts", starts - s0, 1);
    chk("stops", stops - p0, 1);
    chk("scl_pmin", pmin, 4 * Q);
    chk("scl_pmax", pmax, 4 * Q);
    if (poke) begin
      repeat (30) @(posedge clk);
      #1;
      chk("poke_ready", 32'(ready), 1);
      chk("poke_starts", starts - s0, 1);
    end
  endtask

  initial begin
    int s0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_oe", 32'(sda_oe), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_err", 32'(ack_err), 0);
    chk("rst_dout", 32'(data_out), 0);
    rst = 0;
    @(posedge clk);
    #1;
    run_txn(7'h50, 0, 8'hA5, 1, 1, 8'h00, 0);
    run_txn(7'h51, 1, 8'h00, 1, 1, 8'h3C, 0);
    run_txn(7'h50, 0, 8'h11, 0, 1, 8'h00, 0);
    run_txn(7'h22, 0, 8'h5A, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++)
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, 8'($urandom), 0);
    run_txn(7'h2A, 0, 8'h66, 1, 1, 8'h00, 1);
    run_txn(7'h51, 1, 8'h00, 1, 1, 8'hC3, 0);
    // abandon a write while data bit 4 is on the bus
    cfg_aa = 1; cfg_ad = 1; cfg_rw = 0;
    addr = 7'h50; rw = 0; data_in = 8'($urandom); enable = 1;
    s0 = starts;
    @(posedge clk);
    #1;
    enable = 0;
    n = 0;
    while (!(starts > s0 && bits.size() >= 13) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reach", bits.size(), 13);
    chk("rst_in_wdata", 32'(state), 4);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_scl", 32'(scl), 1);
    chk("mid_rst_oe", 32'(sda_oe), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_err", 32'(ack_err), 0);
    chk("mid_rst_dout", 32'(data_out), 0);
    exp_dout = '0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    // enable held high: the next transaction is accepted one cycle after IDLE
    cfg_aa = 1; cfg_ad = 1; cfg_rw = 0;
    addr = 7'h33; rw = 0; data_in = 8'h99; enable = 1;
    s0 = starts;
    wait_ready(0);
    wait_ready(1);
    n = 0;
    while (ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    enable = 0;
    chk("b2b_gap", n, 1);
    wait_ready(1);
    chk("b2b_starts", starts - s0, 2);
    chk("b2b_nbits", bits.size(), 18);
    chk("b2b_err", 32'(ack_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
